// File: rtl/dpd_cfg_pkg.sv
// Shared configuration types for the DPD actuator LUT loader.
// Mirrors LUT geometry used by the actuator's own defines.
package dpd_cfg_pkg;

  localparam int CFG_NUM_LUTS   = 64;
  localparam int CFG_LUT_IDX_W  = 6;
  localparam int CFG_DATA_W     = 32;
  localparam int CFG_ADDR_W     = 10;
  localparam int CFG_RD_LATENCY = 2;

  localparam logic MODE_WRITE  = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/dpd_lut_loader_cmp.sv
// Read-back compare path: delays expected data/address to line up
// with LUT read data, then counts mismatches.
module dpd_readback_cmp
  import dpd_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = CFG_DATA_W,
  parameter int ADDR_WIDTH = CFG_ADDR_W,
  parameter int RD_LATENCY = CFG_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  pending_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  err_flag_o
);

  localparam int L = RD_LATENCY;
  localparam logic [ADDR_WIDTH:0] ERR_MAX =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [L-1:0]          vld_q, vld_d;
  logic [DATA_WIDTH-1:0] exp_q [L];
  logic [DATA_WIDTH-1:0] exp_d [L];
  logic [ADDR_WIDTH-1:0] adr_q [L];
  logic [ADDR_WIDTH-1:0] adr_d [L];
  logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  flag_q, flag_d;
  logic                  miss;

  always_comb begin
    vld_d[0] = push_i;
    exp_d[0] = exp_i;
    adr_d[0] = addr_i;
    for (int i = 1; i < L; i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
      adr_d[i] = adr_q[i-1];
    end
  end

  // Anything still in flight ahead of the compare point
  always_comb begin
    pending_o = push_i;
    for (int i = 0; i < L - 1; i++) begin
      pending_o = pending_o | vld_q[i];
    end
  end

  assign miss = vld_q[L-1] && (rdata_i != exp_q[L-1]);

  always_comb begin
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    if (clr_i) begin
      err_cnt_d = '0;
      first_d   = '0;
    end else if (miss) begin
      if (err_cnt_q == '0) begin
        first_d = adr_q[L-1];
      end
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + (ADDR_WIDTH+1)'(1);
      end
    end
    flag_d = (err_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      flag_q    <= 1'b0;
      for (int i = 0; i < L; i++) begin
        exp_q[i] <= '0;
        adr_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      flag_q    <= flag_d;
      for (int i = 0; i < L; i++) begin
        exp_q[i] <= exp_d[i];
        adr_q[i] <= adr_d[i];
      end
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_q;
  assign err_flag_o       = flag_q;

endmodule

// File: rtl/dpd_lut_loader.sv
// Initiator for the DPD actuator LUT config port: burst write or
// read-back verify of one LUT from a coefficient stream.
module dpd_lut_loader
  import dpd_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = CFG_DATA_W,
  parameter int ADDR_WIDTH = CFG_ADDR_W,
  parameter int NUM_LUTS   = CFG_NUM_LUTS,
  parameter int RD_LATENCY = CFG_RD_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CFG_LUT_IDX_W-1:0] cmd_lut,
  input  logic                     cmd_mode,
  input  logic [ADDR_WIDTH-1:0]    cmd_base,
  input  logic [ADDR_WIDTH:0]      cmd_len,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [ADDR_WIDTH-1:0]    config_addr,
  output logic [DATA_WIDTH-1:0]    config_din,
  input  logic [DATA_WIDTH-1:0]    config_dout,
  output logic [NUM_LUTS-1:0]      config_lutId,
  output logic                     config_web,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH:0]      err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic                     err_flag
);

  state_e                   state_q, state_d;
  logic [CFG_LUT_IDX_W-1:0] lut_q, lut_d;
  logic                     mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]    cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH:0]      rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    din_q, din_d;
  logic                     web_q, web_d;
  logic                     rd_q, rd_d;
  logic                     s_acc;
  logic                     clr;
  logic                     pending;
  logic [NUM_LUTS-1:0]      lut_oh;

  assign cmd_ready = (state_q == ST_IDLE);
  assign s_ready   = (state_q == ST_RUN) && (rem_q != '0);
  assign s_acc     = s_valid && s_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);

  // Out-of-range indices leave the select all-zero
  always_comb begin
    lut_oh = '0;
    if (state_q == ST_RUN || state_q == ST_DRAIN) begin
      for (int i = 0; i < NUM_LUTS; i++) begin
        if (i == int'(lut_q)) lut_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lut_d      = lut_q;
    mode_d     = mode_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    din_d      = din_q;
    web_d      = 1'b0;
    rd_d       = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          lut_d      = cmd_lut;
          mode_d     = cmd_mode;
          cur_addr_d = cmd_base;
          rem_d      = cmd_len;
          clr        = 1'b1;
          state_d    = (cmd_len == '0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (s_acc) begin
          addr_d     = cur_addr_q;
          din_d      = s_data;
          web_d      = (mode_q == MODE_WRITE);
          rd_d       = (mode_q == MODE_VERIFY);
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - (ADDR_WIDTH+1)'(1);
        end else if (rem_q == '0) begin
          state_d = (mode_q == MODE_VERIFY) ? ST_DRAIN : ST_FINISH;
        end
      end
      ST_DRAIN: begin
        if (!pending) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lut_q      <= '0;
      mode_q     <= MODE_WRITE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      web_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lut_q      <= lut_d;
      mode_q     <= mode_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      web_q      <= web_d;
      rd_q       <= rd_d;
    end
  end

  assign config_addr  = addr_q;
  assign config_din   = din_q;
  assign config_web   = web_q;
  assign config_lutId = lut_oh;

  dpd_readback_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RD_LATENCY(RD_LATENCY)
  ) u_cmp (
    .clk              (clk),
    .rst_n            (rst_n),
    .clr_i            (clr),
    .push_i           (rd_q),
    .exp_i            (din_q),
    .addr_i           (addr_q),
    .rdata_i          (config_dout),
    .pending_o        (pending),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err_addr),
    .err_flag_o       (err_flag)
  );

endmodule

// File: doc/dpd_lut_loader.md
Name: dpd_lut_loader

Overview:
- Initiator side of the DPD actuator LUT configuration port.
- Accepts a command (target LUT id, mode, base address, length) plus a valid/ready stream of 32-bit {I,Q} coefficient words.
- In WRITE mode it burst-writes the words into the selected LUT. In VERIFY mode it reads the LUT back and compares against the stream, counting mismatches.
- Sits between the AXI register/DMA front end and the actuator's config_* port; clk is the actuator's config_clk.

Parameters:
- DATA_WIDTH, 32, coefficient word width, {I[31:16], Q[15:0]}.
- ADDR_WIDTH, 10, LUT address width (1024 entries).
- NUM_LUTS, 64, number of LUTs (I_DELAY_MAX*J_DELAY_MAX); width of the config_lutId one-hot.
- RD_LATENCY, 2, cycles from config_addr presented to matching config_dout valid.

Ports:
- clk  in  1  clock; tied to the actuator's config_clk.
- rst_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_lut  in  6  LUT index 0..NUM_LUTS-1; bit lut of config_lutId is asserted.
- cmd_mode  in  1  0 = WRITE, 1 = VERIFY.
- cmd_base  in  ADDR_WIDTH  first LUT address.
- cmd_len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- s_data  in  DATA_WIDTH  coefficient: write data or expected value.
- s_valid  in  1  stream valid.
- s_ready  out  1  stream ready.
- config_addr  out  ADDR_WIDTH  LUT address.
- config_din  out  DATA_WIDTH  LUT write data.
- config_dout  in  DATA_WIDTH  LUT read data.
- config_lutId  out  NUM_LUTS  one-hot LUT select.
- config_web  out  1  write strobe; 1 = write.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse at end of command.
- err_cnt  out  ADDR_WIDTH+1  VERIFY mismatch count for the last command.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch.
- err_flag  out  1  err_cnt != 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State -> IDLE.
  - All outputs 0, including config_web, config_lutId, busy, done, err_cnt, first_err_addr.
  - Takes effect mid-operation too: a partial burst is abandoned, no done pulse is generated, and no further config_web is issued.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - cmd_ready=1, s_ready=0, config_lutId=0, config_web=0.
  - On command accept: latch the fields, clear err_cnt, first_err_addr and err_flag, set busy=1.
  - cmd_len=0 -> FINISH; otherwise -> RUN.
- RUN:
  - cmd_ready=0.
  - s_ready=1 while remaining count > 0.
  - config_lutId = one-hot(cmd_lut), held constant through RUN and DRAIN.
  - Each accepted word (s_valid && s_ready) registers config_addr=cur_addr and config_din=s_data on the next edge, with config_web=1 (WRITE) or 0 (VERIFY) for exactly that cycle.
  - cur_addr increments modulo 2^ADDR_WIDTH, so base+len past the top wraps to 0.
  - With s_valid low: config_web=0 and config_addr holds.
  - Throughput: 1 word/cycle.
  - After the last word is accepted: WRITE -> FINISH; VERIFY -> DRAIN.
- VERIFY compare:
  - Expected data and address are pushed into a shift pipeline of depth RD_LATENCY, tagged valid.
  - When the tagged entry emerges, compare config_dout to the expected value.
  - On mismatch: err_cnt++ (saturating at 2^ADDR_WIDTH). If err_cnt was 0, capture first_err_addr.
  - err_flag is registered with err_cnt.
- DRAIN: wait until the compare pipeline is empty (RD_LATENCY cycles after the last read issue), then -> FINISH.
- FINISH:
  - done=1 for one cycle, busy=0 on the following cycle, config_lutId=0, then -> IDLE.
  - err_cnt, first_err_addr and err_flag hold until the next command accept.
- Latency:
  - Write appears on config_* 1 cycle after stream accept.
  - WRITE command: done 2 cycles after the last accept (register stage + FINISH).
  - VERIFY command: done RD_LATENCY+2 cycles after the last accept.
- Out-of-range cmd_lut (>= NUM_LUTS): command is accepted, config_lutId=0, the stream is still consumed, and done is pulsed. Writes hit nothing.
- Back-to-back commands: cmd_ready reasserts in IDLE the cycle after FINISH; no overlap.

Decomposition:
- Shared package dpd_cfg_pkg:
  - state encoding;
  - MODE_WRITE and MODE_VERIFY constants;
  - NUM_LUTS and LUT index width, shared with the actuator's defines.
- One natural sub-module: dpd_readback_cmp, holding the RD_LATENCY expected-data/address pipeline plus the comparator and error counters.

Test Plan:
- WRITE, lut=9, base=0, len=4, data 0x00010002.. with s_valid constant -> config_lutId=1<<9, config_web high 4 consecutive cycles, addr 0..3; done 2 cycles after the 4th accept; err_cnt=0.
- WRITE base=0x3FE, len=4 -> config_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- VERIFY with a behavioural LUT model (RD_LATENCY=2) preloaded identical to the stream, len=16 -> err_cnt=0, err_flag=0, done at last accept+4.
- VERIFY with addr 5 and 7 corrupted -> err_cnt=2, first_err_addr=5, err_flag=1.
- s_valid toggled 1,0,1,0 during WRITE -> config_web pulses only on accept cycles; no duplicate or skipped address.
- rst_n low for 1 cycle mid-burst, then cmd_len=0 -> all outputs 0 after the reset edge, no done for the aborted command; the next command pulses done 1 cycle after accept with no config_web activity.
